// File: rtl/bundle_sequencer.sv
// ---------------------------------------------------------------------------
// bundle_sequencer
//
// Sequences the signed bundling counter over a multi-dimension hypervector
// bundling job. For every output dimension the counter is cleared, item_num
// accumulation rounds are taken from the core array, the counter pipeline is
// drained, and the counter sign bit is sampled. The resulting majority bits
// are packed LSB-first into OUT_W-bit words for a ready/valid consumer.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   start        job start pulse (ignored while busy)
//   item_num     rounds per dimension, sampled at start
//   dim_num      dimensions in the job, sampled at start
//   round_valid  cores present one round of results
//   round_ready  sequencer accepts a round (combinational)
//   core_valid   per-lane result present in this round
//   store        per-lane store strobe to the counter (combinational)
//   store_flag   round strobe to the counter (combinational)
//   counter_clr  synchronous clear to the counter (registered)
//   sign_bit     counter sign bit, 1 = negative sum
//   out_data     packed majority bits, LSB = lowest dimension (registered)
//   out_valid    out_data valid (registered)
//   out_ready    consumer accepts out_data
//   busy         job in progress (registered)
//   done         one-cycle pulse at job end (registered)
// ---------------------------------------------------------------------------
module bundle_sequencer #(
    parameter int                  CORENUM = 32,
    parameter logic [CORENUM-1:0]  MASK    = 32'h0000_3FFF,
    parameter int                  W       = 30,
    parameter int                  DW      = 16,
    parameter int                  OUT_W   = 32,
    parameter int                  LAT     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W-1:0]       item_num,
    input  logic [DW-1:0]      dim_num,
    input  logic               round_valid,
    output logic               round_ready,
    input  logic [CORENUM-1:0] core_valid,
    output logic [CORENUM-1:0] store,
    output logic               store_flag,
    output logic               counter_clr,
    input  logic               sign_bit,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    // Bit index needs one extra bit so it can reach OUT_W itself.
    localparam int BW  = $clog2(OUT_W);
    localparam int BIW = BW + 1;
    localparam int DCW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_SAMPLE = 3'd4,
        S_EMIT   = 3'd5
    } state_t;

    state_t             state_q,       state_d;
    logic [W-1:0]       item_num_q,    item_num_d;
    logic [DW-1:0]      dim_num_q,     dim_num_d;
    logic [W-1:0]       item_cnt_q,    item_cnt_d;
    logic [DW-1:0]      dim_cnt_q,     dim_cnt_d;
    logic [BW:0]        bit_idx_q,     bit_idx_d;
    logic [DCW-1:0]     drain_cnt_q,   drain_cnt_d;
    logic [OUT_W-1:0]   pack_q,        pack_d;
    logic [OUT_W-1:0]   out_data_q,    out_data_d;
    logic               out_valid_q,   out_valid_d;
    logic               done_q,        done_d;
    logic               busy_q,        busy_d;
    logic               counter_clr_q, counter_clr_d;

    // Round handshake strobes are decoded straight from state so the cores
    // see acceptance in the same cycle they present a round.
    assign round_ready = (state_q == S_ISSUE);
    assign store_flag  = round_ready & round_valid;
    assign store       = store_flag ? (core_valid & MASK) : {CORENUM{1'b0}};

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign counter_clr = counter_clr_q;

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_d       = state_q;
        item_num_d    = item_num_q;
        dim_num_d     = dim_num_q;
        item_cnt_d    = item_cnt_q;
        dim_cnt_d     = dim_cnt_q;
        bit_idx_d     = bit_idx_q;
        drain_cnt_d   = drain_cnt_q;
        pack_d        = pack_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        done_d        = 1'b0;
        counter_clr_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high in the done cycle, which masks a start
                // arriving together with done.
                if (start && !busy_q) begin
                    if (dim_num != {DW{1'b0}}) begin
                        item_num_d    = item_num;
                        dim_num_d     = dim_num;
                        dim_cnt_d     = {DW{1'b0}};
                        bit_idx_d     = {BIW{1'b0}};
                        pack_d        = {OUT_W{1'b0}};
                        counter_clr_d = 1'b1;
                        state_d       = S_CLEAR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLEAR: begin
                item_cnt_d  = {W{1'b0}};
                drain_cnt_d = {DCW{1'b0}};
                if (item_num_q == {W{1'b0}}) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (round_valid) begin
                    // item_cnt_q < item_num_q <= 2^W-1, so the increment cannot wrap.
                    item_cnt_d = item_cnt_q + W'(1'b1);
                    if (item_cnt_d == item_num_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_DRAIN: begin
                if (drain_cnt_q == DCW'(LAT - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1'b1);
                    state_d     = S_DRAIN;
                end
            end

            S_SAMPLE: begin
                // Non-negative sum (including a tie) becomes a 1.
                pack_d[bit_idx_q[BW-1:0]] = ~sign_bit;
                bit_idx_d = bit_idx_q + BIW'(1'b1);
                dim_cnt_d = dim_cnt_q + DW'(1'b1);
                if ((bit_idx_d == BIW'(OUT_W)) || (dim_cnt_d == dim_num_q)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pack_d;
                    state_d     = S_EMIT;
                end else begin
                    counter_clr_d = 1'b1;
                    state_d       = S_CLEAR;
                end
            end

            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_data_d  = {OUT_W{1'b0}};
                    pack_d      = {OUT_W{1'b0}};
                    bit_idx_d   = {BIW{1'b0}};
                    if (dim_cnt_q == dim_num_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        counter_clr_d = 1'b1;
                        state_d       = S_CLEAR;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy covers the job-end done cycle but not a zero-dimension done.
        busy_d = (state_d != S_IDLE) || (done_d && (state_q != S_IDLE));
    end

    // State and registered-output flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            item_num_q    <= {W{1'b0}};
            dim_num_q     <= {DW{1'b0}};
            item_cnt_q    <= {W{1'b0}};
            dim_cnt_q     <= {DW{1'b0}};
            bit_idx_q     <= {BIW{1'b0}};
            drain_cnt_q   <= {DCW{1'b0}};
            pack_q        <= {OUT_W{1'b0}};
            out_data_q    <= {OUT_W{1'b0}};
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            counter_clr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            item_num_q    <= item_num_d;
            dim_num_q     <= dim_num_d;
            item_cnt_q    <= item_cnt_d;
            dim_cnt_q     <= dim_cnt_d;
            bit_idx_q     <= bit_idx_d;
            drain_cnt_q   <= drain_cnt_d;
            pack_q        <= pack_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            counter_clr_q <= counter_clr_d;
        end
    end

endmodule

// File: tb/tb_bundle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bundle_sequencer
//
// Randomized bench for bundle_sequencer. Jobs are described as tables of
// rounds (lane valid bits and +1/-1 lane results); the expected packed words
// are computed from those tables by summing the masked, valid lane votes per
// dimension. A behavioural counter with a LAT-deep sign pipeline stands in for
// the bundling counter. A negedge monitor pops expected words whenever the
// DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_bundle_sequencer;

    localparam int          CORENUM = 32;
    localparam int          W       = 30;
    localparam int          DW      = 16;
    localparam int          OUT_W   = 32;
    localparam int          LAT     = 3;
    localparam logic [31:0] MASK    = 32'h0000_3FFF;

    localparam int DM_RAND = 0, DM_POS = 1, DM_NEG = 2, DM_ALT = 3;
    localparam int RV_RAND = 0, RV_ALL = 1;
    localparam int OR_RAND = 0, OR_ALL = 1, OR_STALL = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [W-1:0]       item_num = '0;
    logic [DW-1:0]      dim_num = '0;
    logic               round_valid = 1'b0;
    logic               round_ready;
    logic [CORENUM-1:0] core_valid = '0;
    logic [CORENUM-1:0] store;
    logic               store_flag;
    logic               counter_clr;
    logic               sign_bit;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               busy;
    logic               done;
    logic [31:0]        res_s = '0;

    always #5 clk = ~clk;

    bundle_sequencer #(
        .CORENUM(CORENUM), .MASK(MASK), .W(W), .DW(DW), .OUT_W(OUT_W), .LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .item_num(item_num), .dim_num(dim_num),
        .round_valid(round_valid), .round_ready(round_ready), .core_valid(core_valid),
        .store(store), .store_flag(store_flag), .counter_clr(counter_clr),
        .sign_bit(sign_bit), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural bundling counter: not affected by rst.
    function automatic int lane_delta(input logic [31:0] st, input logic [31:0] r);
        int s = 0;
        for (int i = 0; i < 32; i++) if (st[i]) s += r[i] ? 1 : -1;
        return s;
    endfunction

    int         cnt_sum = 0;
    logic [1:0] sign_pipe = 2'b00;
    assign sign_bit = sign_pipe[1];

    always @(posedge clk) begin
        if (counter_clr) cnt_sum <= 0;
        else if (store_flag) cnt_sum <= cnt_sum + lane_delta(store, res_s);
        sign_pipe <= {sign_pipe[0], (cnt_sum < 0)};
    end

    // Scoreboard and protocol monitor.
    logic [31:0] exp_q[$];
    int          n_flag = 0;
    int          n_clr  = 0;
    logic        prev_ov = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_od = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (store_flag) begin
                n_flag <= n_flag + 1;
                check("store_lanes", store, core_valid & MASK);
            end else begin
                check("store_idle", store, 32'h0);
            end
            if (counter_clr) n_clr <= n_clr + 1;
            if (prev_ov && !prev_hs) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_od);
            end
            if (out_valid) check("emit_quiet", {store_flag, counter_clr}, 2'b00);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
            end
            prev_ov <= out_valid;
            prev_hs <= out_valid && out_ready;
            prev_od <= out_data;
        end else begin
            prev_ov <= 1'b0;
            prev_hs <= 1'b0;
        end
    end

    // Runs one job; abort_after>0 asserts rst mid-ISSUE after that many rounds.
    task automatic run_job(input int dims, input int items, input int dm, input int rvm,
                           input int orm, input int abort_after, input int exp_lat);
        logic [31:0] cv_t[$];
        logic [31:0] rs_t[$];
        logic [31:0] mask_v = MASK;
        logic [31:0] w;
        int nr, idx, cyc, clr_cyc, done_cyc, ov_run, f0, c0, bp, s;
        bit fin, aborted;
        nr = dims * items;
        idx = 0; cyc = 0; clr_cyc = -1; done_cyc = -1; ov_run = 0;
        fin = 1'b0; aborted = 1'b0;
        for (int d = 0; d < dims; d++) begin
            for (int r = 0; r < items; r++) begin
                cv_t.push_back((dm == DM_RAND) ? $urandom : 32'hFFFF_FFFF);
                case (dm)
                    DM_POS:  rs_t.push_back(32'hFFFF_FFFF);
                    DM_NEG:  rs_t.push_back(32'h0);
                    DM_ALT:  rs_t.push_back((d % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
                    default: rs_t.push_back($urandom);
                endcase
            end
        end
        // Reference: per-dimension majority of masked valid lane votes.
        w = '0; bp = 0;
        for (int d = 0; d < dims; d++) begin
            s = 0;
            for (int r = 0; r < items; r++)
                for (int i = 0; i < 32; i++)
                    if (mask_v[i] && cv_t[d*items+r][i]) s += rs_t[d*items+r][i] ? 1 : -1;
            w[bp] = (s >= 0);
            bp++;
            if (bp == OUT_W || d == dims - 1) begin
                exp_q.push_back(w);
                w = '0; bp = 0;
            end
        end
        f0 = n_flag; c0 = n_clr;

        @(posedge clk); #1;
        start = 1'b1; item_num = items[W-1:0]; dim_num = dims[DW-1:0];
        @(posedge clk); #1;
        start = 1'b0;

        while (!fin && cyc < 20000) begin
            round_valid = (idx < nr) && (rvm == RV_ALL || $urandom_range(3) != 0);
            core_valid  = (idx < nr) ? cv_t[idx] : 32'h0;
            res_s       = (idx < nr) ? rs_t[idx] : 32'h0;
            case (orm)
                OR_ALL:   out_ready = 1'b1;
                OR_STALL: out_ready = (ov_run >= 5);
                default:  out_ready = ($urandom_range(1) == 1);
            endcase
            @(negedge clk);
            if (cyc == 0) begin
                if (dims > 0) begin
                    check("first_clr", counter_clr, 1'b1);
                    check("first_busy", busy, 1'b1);
                end else begin
                    check("zero_dim_done", done, 1'b1);
                end
            end
            if (counter_clr && clr_cyc < 0) clr_cyc = cyc;
            if (out_valid && !out_ready) ov_run++;
            else if (!out_valid) ov_run = 0;
            if (round_valid && round_ready) idx++;
            if (abort_after > 0 && idx == abort_after) begin
                check("pre_rst_flag", store_flag, 1'b1);
                #2 rst = 1'b0;
                #1;
                check("rst_data", {out_valid, out_data, busy, done, counter_clr}, 36'h0);
                check("rst_store", {round_ready, store_flag, store}, 34'h0);
                exp_q.delete();
                @(posedge clk); #1;
                rst = 1'b1;
                round_valid = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
                check("busy_at_done", busy, (dims > 0) ? 1'b1 : 1'b0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        round_valid = 1'b0;
        if (!aborted) begin
            if (!fin) begin
                total_cnt++;
                $display("FAIL job_timeout: got no done expected done within 20000 cycles");
            end
            @(posedge clk); #1;
            check("busy_after", busy, 1'b0);
            check("words_left", exp_q.size(), 0);
            check("flag_count", n_flag - f0, nr);
            check("clr_count", n_clr - c0, dims);
            if (exp_lat >= 0) check("job_latency", done_cyc - clr_cyc, exp_lat);
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {out_valid, out_data, busy, done, counter_clr}, 36'h0);
        check("rst_comb", {round_ready, store_flag, store}, 34'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_job(1, 3, DM_POS, RV_ALL, OR_ALL, 0, 9);
        run_job(40, 2, DM_ALT, RV_RAND, OR_ALL, 0, -1);
        run_job(3, 2, DM_RAND, RV_RAND, OR_STALL, 0, -1);
        run_job(4, 0, DM_RAND, RV_RAND, OR_RAND, 0, -1);
        run_job(0, 5, DM_RAND, RV_RAND, OR_ALL, 0, -1);
        run_job(3, 5, DM_RAND, RV_ALL, OR_ALL, 4, -1);
        run_job(1, 3, DM_NEG, RV_RAND, OR_ALL, 0, -1);
        for (int k = 0; k < 12; k++)
            run_job($urandom_range(70, 1), $urandom_range(6, 0), DM_RAND,
                    RV_RAND, OR_RAND, 0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
